// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle restoring shift-subtract divider: q = x / y, r = x mod y.
//   One quotient bit is produced per clock, MSB first, so a division takes
//   N cycles in CALC followed by a single DONE cycle.  Divide-by-zero is
//   detected at acceptance and skips CALC entirely.
//
// Optional build macro:
//   SEQ_DIVIDER_SIGNED_EN - two's complement operands and results. The core
//   divides magnitudes; signs are restored on the edge that enters DONE.
//   Left undefined, the block is purely unsigned with no sign logic.
//
// Ports:
//   clock  in   rising-edge system clock
//   reset  in   asynchronous, active-high reset
//   start  in   request pulse, sampled only in IDLE
//   x      in   [N-1:0] dividend, captured on accepted start
//   y      in   [N-1:0] divisor, captured on accepted start
//   q      out  [N-1:0] quotient, valid from done onward
//   r      out  [N-1:0] remainder, valid from done onward
//   busy   out  high while in CALC
//   done   out  one-cycle pulse when q/r/dbz are written
//   dbz    out  divide-by-zero flag for the current result
//
// N must be at least 2.
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int N = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         busy,
  output logic         done,
  output logic         dbz
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] COUNT_INIT = CW'(N - 1);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [CW-1:0] COUNT_ZERO = {CW{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;

  logic [CW-1:0]   count_r;
  logic [N:0]      p_r;        // partial remainder, one guard bit
  logic [N-1:0]    a_r;        // dividend bits shift out, quotient bits shift in
  logic [N-1:0]    b_r;        // captured divisor magnitude

  logic [N-1:0]    q_r;
  logic [N-1:0]    r_r;
  logic            busy_r;
  logic            done_r;
  logic            dbz_r;

  logic            y_zero_s;
  logic            last_s;
  logic [N:0]      shifted_s;
  logic [N+1:0]    diff_s;
  logic [N:0]      p_next_s;
  logic [N-1:0]    a_next_s;
  logic [N-1:0]    x_mag_s;
  logic [N-1:0]    y_mag_s;
  logic [N-1:0]    q_res_s;
  logic [N-1:0]    r_res_s;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic            x_neg_r;
  logic            y_neg_r;
`endif

  assign q    = q_r;
  assign r    = r_r;
  assign busy = busy_r;
  assign done = done_r;
  assign dbz  = dbz_r;

  assign y_zero_s = (y == {N{1'b0}});
  assign last_s   = (count_r == COUNT_ZERO);

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  always_comb begin
    shifted_s = {p_r[N-1:0], a_r[N-1]};
    // Extra MSB of the difference acts as the borrow: set means the trial went negative.
    diff_s    = {1'b0, shifted_s} - {2'b00, b_r};
    if (diff_s[N+1]) begin
      p_next_s = shifted_s;
    end else begin
      p_next_s = diff_s[N:0];
    end
    a_next_s  = {a_r[N-2:0], ~diff_s[N+1]};
  end

  // Operand magnitudes at capture and sign restoration of the final result.
  always_comb begin
    x_mag_s = x;
    y_mag_s = y;
    q_res_s = a_next_s;
    r_res_s = p_next_s[N-1:0];
`ifdef SEQ_DIVIDER_SIGNED_EN
    if (x[N-1]) begin
      x_mag_s = {N{1'b0}} - x;
    end else begin
      x_mag_s = x;
    end
    if (y[N-1]) begin
      y_mag_s = {N{1'b0}} - y;
    end else begin
      y_mag_s = y;
    end
    // Most-negative / -1 yields magnitude 2^(N-1), which wraps back to most-negative.
    if (x_neg_r ^ y_neg_r) begin
      q_res_s = {N{1'b0}} - a_next_s;
    end else begin
      q_res_s = a_next_s;
    end
    if (x_neg_r) begin
      r_res_s = {N{1'b0}} - p_next_s[N-1:0];
    end else begin
      r_res_s = p_next_s[N-1:0];
    end
`endif
  end

  // Next-state logic for the IDLE/CALC/DONE sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (y_zero_s) begin
            state_s = DONE;
          end else begin
            state_s = CALC;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = CALC;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Status flags registered from the next state so they line up with CALC/DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s == CALC);
      done_r <= (state_s == DONE);
    end
  end

  // Datapath: operand capture, iteration and result write on DONE entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_r     <= {(N+1){1'b0}};
      a_r     <= {N{1'b0}};
      b_r     <= {N{1'b0}};
      count_r <= COUNT_ZERO;
      q_r     <= {N{1'b0}};
      r_r     <= {N{1'b0}};
      dbz_r   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      x_neg_r <= 1'b0;
      y_neg_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            if (y_zero_s) begin
              q_r   <= {N{1'b1}};
              r_r   <= x;
              dbz_r <= 1'b1;
            end else begin
              a_r     <= x_mag_s;
              b_r     <= y_mag_s;
              p_r     <= {(N+1){1'b0}};
              count_r <= COUNT_INIT;
`ifdef SEQ_DIVIDER_SIGNED_EN
              x_neg_r <= x[N-1];
              y_neg_r <= y[N-1];
`endif
            end
          end
        end
        CALC: begin
          p_r     <= p_next_s;
          a_r     <= a_next_s;
          count_r <= count_r - COUNT_ONE;
          if (last_s) begin
            q_r   <= q_res_s;
            r_r   <= r_res_s;
            dbz_r <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  localparam int N = 6;
  localparam int BUDGET = 40;

  logic         clock;
  logic         reset;
  logic         start;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic [N-1:0] q;
  logic [N-1:0] r;
  logic         busy;
  logic         done;
  logic         dbz;

  int vectors;
  int miscompares;

  seq_divider #(.N(N)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .x     (x),
    .y     (y),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: plain arithmetic on the operands as numbers.
  function automatic void ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] eq, output logic [N-1:0] er,
                                  output logic ed);
    int qi;
    int ri;
    if (b == 0) begin
      eq = '1;
      er = a;
      ed = 1'b1;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      int sa;
      int sb;
      sa = $signed(a);
      sb = $signed(b);
      qi = sa / sb;
      ri = sa % sb;
`else
      qi = int'(a) / int'(b);
      ri = int'(a) % int'(b);
`endif
      eq = qi[N-1:0];
      er = ri[N-1:0];
      ed = 1'b0;
    end
  endfunction

  task automatic launch(input logic [N-1:0] xv, input logic [N-1:0] yv);
    x = xv;
    y = yv;
    start = 1'b1;
  endtask

  // Steps clocks until done; cyc is the sample index after the accepting edge (-1 on timeout).
  task automatic wait_done(output int cyc, output int busy_n, output int overlap);
    cyc = -1;
    busy_n = 0;
    overlap = 0;
    for (int c = 1; c <= BUDGET; c++) begin
      @(posedge clock);
      #1;
      start = 1'b0;
      if (busy) busy_n++;
      if (busy && done) overlap++;
      if (done) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic check_result(input string name, input logic [N-1:0] xv, input logic [N-1:0] yv);
    logic [N-1:0] eq;
    logic [N-1:0] er;
    logic         ed;
    ref_div(xv, yv, eq, er, ed);
    vectors++;
    if (q !== eq || r !== er || dbz !== ed) begin
      miscompares++;
      $display("FAIL %s x=%0d y=%0d: got q=%0d r=%0d dbz=%0b, want q=%0d r=%0d dbz=%0b",
               name, xv, yv, q, r, dbz, eq, er, ed);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    x = '0;
    y = '0;
    #1;
    vectors++;
    if ({q, r, busy, done, dbz} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got q=%0d r=%0d busy=%0b done=%0b dbz=%0b, want all 0",
               q, r, busy, done, dbz);
    end
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    vectors++;
    if ({q, r, busy, done, dbz} !== '0) begin
      miscompares++;
      $display("FAIL after_reset: got q=%0d r=%0d busy=%0b done=%0b dbz=%0b, want all 0",
               q, r, busy, done, dbz);
    end
  endtask

  task automatic test_basic;
    int cyc, bn, ov;
    launch(6'd45, 6'd7);
    wait_done(cyc, bn, ov);
    vectors++;
    if (cyc != N + 1 || bn != N || ov != 0) begin
      miscompares++;
      $display("FAIL basic_latency: got done at %0d busy %0d overlap %0d, want %0d %0d 0",
               cyc, bn, ov, N + 1, N);
    end
    check_result("basic_45_7", 6'd45, 6'd7);
    @(posedge clock);
    #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_single_done: got done=%0b busy=%0b, want 0 0", done, busy);
    end
    check_result("basic_hold", 6'd45, 6'd7);
  endtask

  task automatic test_back_to_back;
    int cyc, bn, ov;
    logic [N-1:0] eq, er;
    logic ed;
    launch(6'd63, 6'd1);
    wait_done(cyc, bn, ov);
    check_result("b2b_first", 6'd63, 6'd1);
    @(posedge clock);
    #1;
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_first_single_done: got done=%0b, want 0", done);
    end
    launch(6'd5, 6'd9);
    @(posedge clock);
    #1;
    start = 1'b0;
    ref_div(6'd63, 6'd1, eq, er, ed);
    vectors++;
    if (busy !== 1'b1 || q !== eq || r !== er) begin
      miscompares++;
      $display("FAIL b2b_hold_during_busy: got busy=%0b q=%0d r=%0d, want 1 %0d %0d",
               busy, q, r, eq, er);
    end
    wait_done(cyc, bn, ov);
    vectors++;
    if (cyc != N || ov != 0) begin
      miscompares++;
      $display("FAIL b2b_second_latency: got %0d overlap %0d, want %0d 0", cyc, ov, N);
    end
    check_result("b2b_second", 6'd5, 6'd9);
    @(posedge clock);
    #1;
  endtask

  task automatic test_dbz;
    int cyc, bn, ov;
    launch(6'd12, 6'd0);
    wait_done(cyc, bn, ov);
    vectors++;
    if (cyc != 1 || bn != 0) begin
      miscompares++;
      $display("FAIL dbz_latency: got done at %0d busy %0d, want 1 0", cyc, bn);
    end
    check_result("dbz_12_0", 6'd12, 6'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic test_ignore_start;
    int dones;
    dones = 0;
    launch(6'd45, 6'd7);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clock);
      #1;
      start = 1'b0;
      if (c == 2) launch(6'd1, 6'd1);
      if (c == N + 1) start = 1'b1;   // also pulse during DONE
      if (done) dones++;
      if (c == N + 1) check_result("ignore_result", 6'd45, 6'd7);
    end
    start = 1'b0;
    vectors++;
    if (dones != 1) begin
      miscompares++;
      $display("FAIL ignore_done_count: got %0d, want 1", dones);
    end
  endtask

  task automatic test_reset_mid;
    int cyc, bn, ov;
    int dones;
    dones = 0;
    launch(6'd45, 6'd7);
    repeat (3) begin
      @(posedge clock);
      #1;
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({q, r, busy, done, dbz} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_async: got q=%0d r=%0d busy=%0b done=%0b dbz=%0b, want all 0",
               q, r, busy, done, dbz);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock);
      #1;
      if (done || busy) dones++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL reset_mid_no_done: got %0d active cycles, want 0", dones);
    end
    launch(6'd20, 6'd6);
    wait_done(cyc, bn, ov);
    check_result("reset_mid_20_6", 6'd20, 6'd6);
    @(posedge clock);
    #1;
  endtask

  task automatic test_random;
    int cyc, bn, ov;
    logic [N-1:0] xv, yv;
    for (int i = 0; i < 40; i++) begin
      xv = N'($urandom);
      yv = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      launch(xv, yv);
      @(posedge clock);
      #1;
      start = 1'b0;
      x = N'($urandom);        // operands must already be captured
      y = N'($urandom);
      if (done) cyc = 1; else begin
        wait_done(cyc, bn, ov);
        if (cyc > 0) cyc++;
      end
      vectors++;
      if (cyc != ((yv == 0) ? 1 : N + 1)) begin
        miscompares++;
        $display("FAIL random_latency x=%0d y=%0d: got %0d", xv, yv, cyc);
      end
      check_result("random", xv, yv);
      @(posedge clock);
      #1;
    end
  endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
  task automatic test_signed;
    int cyc, bn, ov;
    logic [N-1:0] xs[4] = '{6'b100111, 6'b100000, 6'd25, 6'b111001};
    logic [N-1:0] ys[4] = '{6'd7, 6'b111111, 6'b111001, 6'd0};
    logic [N-1:0] wq[4] = '{6'b111101, 6'b100000, 6'b111101, 6'b111111};
    logic [N-1:0] wr[4] = '{6'b111100, 6'd0, 6'd4, 6'b111001};
    for (int i = 0; i < 4; i++) begin
      launch(xs[i], ys[i]);
      wait_done(cyc, bn, ov);
      vectors++;
      if (q !== wq[i] || r !== wr[i]) begin
        miscompares++;
        $display("FAIL signed_case%0d: got q=%b r=%b, want q=%b r=%b", i, q, r, wq[i], wr[i]);
      end
      @(posedge clock);
      #1;
    end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_dbz();
    test_ignore_start();
    test_reset_mid();
    test_random();
`ifdef SEQ_DIVIDER_SIGNED_EN
    test_signed();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
